// File: rtl/multdiv_scheduler.sv
// Issues mult/div from X to the shared multi-cycle unit, tracks it to completion,
// stalls decode on hazards against the pending result, and holds the writeback slot.
module multdiv_scheduler #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_IR,
  input  logic [31:0] DX_IR,
  input  logic [31:0] DX_A,
  input  logic [31:0] DX_B,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        md_mult,
  output logic        md_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_accept,
  output logic        stall,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0] EXC_RD = 5'd30;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      rd_q;
  logic            div_q;

  // mult is aluop 00110, div is 00111: they differ only in aluop[0] (IR bit 2)
  function automatic logic is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'b00000) && (ir[6:3] == 4'b0011);
  endfunction

  logic       x_md;
  logic       x_div;
  logic       issue;
  logic       pending;
  logic [4:0] pend_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic       ready_ok;

  assign x_md     = is_md(DX_IR);
  assign x_div    = DX_IR[2];
  assign issue    = (state == IDLE) && x_md;
  assign pending  = x_md || (state != IDLE);
  assign pend_rd  = issue ? DX_IR[26:22] : rd_q;
  assign fd_rs    = FD_IR[21:17];
  assign fd_rt    = FD_IR[16:12];
  assign busy     = (state != IDLE);
  // the unit cannot answer in its own start cycle
  assign ready_ok = md_ready && !(md_mult || md_div);

  assign stall = pending && (
                   ((fd_rs == pend_rd) && (pend_rd != 5'd0)) ||
                   ((fd_rt == pend_rd) && (pend_rd != 5'd0)) ||
                   (fd_rs == EXC_RD) || (fd_rt == EXC_RD) ||
                   is_md(FD_IR));

  logic unused_bits;
  assign unused_bits = ^{FD_IR[26:22], FD_IR[11:7], FD_IR[1:0], DX_IR[21:7], DX_IR[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= '0;
      div_q    <= 1'b0;
      md_mult  <= 1'b0;
      md_div   <= 1'b0;
      md_opA   <= '0;
      md_opB   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      md_mult <= 1'b0;
      md_div  <= 1'b0;
      case (state)
        IDLE: begin
          if (x_md) begin
            md_opA  <= DX_A;
            md_opB  <= DX_B;
            rd_q    <= DX_IR[26:22];
            div_q   <= x_div;
            md_mult <= !x_div;
            md_div  <= x_div;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (ready_ok && md_exception) begin
            wb_valid <= 1'b1;
            wb_rd    <= EXC_RD;
            wb_data  <= div_q ? 32'd5 : 32'd4;
            state    <= DONE;
          end else if (ready_ok && (rd_q != 5'd0)) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= md_result;
            state    <= DONE;
          end else if (ready_ok) begin
            state <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            wb_valid <= 1'b1;
            wb_rd    <= EXC_RD;
            wb_data  <= div_q ? 32'd5 : 32'd4;
            state    <= DONE;
          end
        end
        DONE: begin
          if (wb_accept) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
